// File: rtl/bin_pkg.sv
// Shared constants and helpers for the key debounce front end.
//   DEF_*  : default build values for a 50 MHz system clock.
//   clog2w : ceil(log2(v)) with a minimum of 1, used to size counters.
package bin_pkg;

  localparam int unsigned DEF_TICK_DIV     = 1250000;  // 40 Hz sample rate at 50 MHz
  localparam int unsigned DEF_STABLE       = 2;
  localparam int unsigned DEF_HOLD_TICKS   = 20;
  localparam int unsigned DEF_REPEAT_TICKS = 4;

  function automatic int unsigned clog2w(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/bin_debounce_chan.sv
// One key channel: 2-FF synchroniser, sample history, debounced state,
// hold/auto-repeat counter and one-cycle event pulses.
//   CLK, RST_N : clock, asynchronous active-low reset
//   SAMPLE     : one-cycle sample strobe from the shared tick divider
//   BIN        : raw asynchronous key pin
//   LEVEL      : debounced pressed state (1 = pressed)
//   PRESS      : pulse on accepted released->pressed change
//   RELEASE    : pulse on accepted pressed->released change
//   REPEAT     : pulse per auto-repeat event while held
module bin_debounce_chan
  import bin_pkg::*;
#(
  parameter int unsigned STABLE       = DEF_STABLE,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SAMPLE,
  input  logic BIN,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic REPEAT
);

  localparam int unsigned HOLD_W = clog2w(HOLD_TICKS + REPEAT_TICKS + 1);
  // Pin level of a released key; also the value that flips the pin into "act" form.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
  // Reloading to HOLD-REPEAT makes every later repeat REPEAT_TICKS apart.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD =
      (REPEAT_TICKS < HOLD_TICKS) ? HOLD_W'(HOLD_TICKS - REPEAT_TICKS) : '0;

  logic [1:0]        sync_q;
  logic              act;
  logic [STABLE-1:0] hist_q, hist_d, hist_next;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              repeat_q, repeat_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;

  always_comb begin
    act       = sync_q[1] ^ IDLE_PIN;
    hist_next = {hist_q[STABLE-2:0], act};
    hold_inc  = hold_q + 1'b1;
    hist_d    = hist_q;
    level_d   = level_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (SAMPLE) begin
      hist_d = hist_next;
      if (!level_q && (&hist_next)) begin
        level_d = 1'b1;
        press_d = 1'b1;
        hold_d  = '0;
      end else if (level_q && !(|hist_next)) begin
        level_d   = 1'b0;
        release_d = 1'b1;
        hold_d    = '0;
      end else if (level_q) begin
        if (hold_q == HOLD_MAX) begin
          // Only reachable with REPEAT_TICKS = 0: saturated, single long-press pulse.
          hold_d = hold_q;
        end else if (hold_inc == HOLD_MAX) begin
          repeat_d = 1'b1;
          hold_d   = (REPEAT_TICKS == 0) ? HOLD_MAX : HOLD_RELOAD;
        end else begin
          hold_d = hold_inc;
        end
      end
    end
  end

  // History is kept in act form, so the released reset value is all zeros.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q    <= {IDLE_PIN, IDLE_PIN};
      hist_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      sync_q    <= {sync_q[0], BIN};
      hist_q    <= hist_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      hold_q    <= hold_d;
    end
  end

  assign LEVEL   = level_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;
  assign REPEAT  = repeat_q;

endmodule

// File: rtl/bin_debounce_multi.sv
// N-channel push-button front end: shared sample-tick divider feeding one
// debounce/auto-repeat channel per key.
//   CLK, RST_N : clock, asynchronous active-low reset
//   BIN        : raw asynchronous key pins
//   TICK       : one-cycle sample-tick strobe
//   LEVEL      : debounced pressed state per channel
//   PRESS      : one-cycle press pulses
//   RELEASE    : one-cycle release pulses
//   REPEAT     : one-cycle auto-repeat pulses
module bin_debounce_multi
  import bin_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE       = DEF_STABLE,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] BIN,
  output logic            TICK,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] REPEAT
);

  localparam int unsigned CNT_W = clog2w(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample;
  logic             tick_q;

  // Channels update on the same edge that registers TICK, so their pulses and
  // new LEVEL line up with the TICK cycle.
  assign sample = (cnt_q == CNT_MAX);
  assign cnt_d  = sample ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= sample;
    end
  end

  assign TICK = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    bin_debounce_chan #(
      .STABLE       (STABLE),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_chan (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .SAMPLE  (sample),
      .BIN     (BIN[i]),
      .LEVEL   (LEVEL[i]),
      .PRESS   (PRESS[i]),
      .RELEASE (RELEASE[i]),
      .REPEAT  (REPEAT[i])
    );
  end

endmodule

// File: tb/tb_bin_debounce_multi.sv
module tb_bin_debounce_multi;

  localparam int TDIV = 4;
  localparam int STB  = 3;
  localparam int HOLD = 5;
  localparam int RPT  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bin = 2'b11;
  logic       tick, tick2;
  logic [1:0] level, press, rel, rep;
  logic [1:0] level2, press2, rel2, rep2;

  always #5 clk = ~clk;

  bin_debounce_multi #(
    .N_CH(2), .TICK_DIV(TDIV), .STABLE(STB), .ACTIVE_LOW(1),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .BIN(bin), .TICK(tick),
    .LEVEL(level), .PRESS(press), .RELEASE(rel), .REPEAT(rep)
  );

  // Single long-press build sharing the same pins and reset.
  bin_debounce_multi #(
    .N_CH(2), .TICK_DIV(TDIV), .STABLE(STB), .ACTIVE_LOW(1),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(0)
  ) u_dut_r0 (
    .CLK(clk), .RST_N(rst_n), .BIN(bin), .TICK(tick2),
    .LEVEL(level2), .PRESS(press2), .RELEASE(rel2), .REPEAT(rep2)
  );

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
    logic [1:0] rpt;
    logic [1:0] rpt0;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   rep0_cnt = 0;

  // Reference model state: consecutive-run counting per channel.
  logic [1:0] m_lvl, m_last;
  int         m_run[2];
  int         m_held[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl  = '0;
    m_last = '0;
    m_run  = '{STB, STB};
    m_held = '{0, 0};
  endtask

  task automatic push_expect(input logic [1:0] b);
    exp_t e;
    logic a;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      a = ~b[c];
      if (a == m_last[c]) m_run[c]++;
      else begin
        m_last[c] = a;
        m_run[c]  = 1;
      end
      if (m_run[c] >= STB && a != m_lvl[c]) begin
        m_lvl[c]  = a;
        m_held[c] = 0;
        if (a) e.prs[c] = 1'b1;
        else   e.rls[c] = 1'b1;
      end else if (m_lvl[c]) begin
        m_held[c]++;
        e.rpt[c]  = (m_held[c] == HOLD) ||
                    (m_held[c] > HOLD && ((m_held[c] - HOLD) % RPT) == 0);
        e.rpt0[c] = (m_held[c] == HOLD);
      end
    end
    e.lvl = m_lvl;
    sb.push_back(e);
  endtask

  task automatic wait_tick(output int cyc, output logic stray);
    cyc   = 0;
    stray = 1'b0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!tick) stray = stray | (|{press, rel, rep, press2, rel2, rep2});
    end while (!tick && cyc < 20);
  endtask

  task automatic step(input string tag, input logic [1:0] b);
    int   cyc;
    logic stray;
    exp_t e;
    bin = b;
    push_expect(b);
    wait_tick(cyc, stray);
    chk({tag, " tick_period"}, 32'(cyc), 32'd4);
    chk({tag, " offtick_pulse"}, 32'(stray), 32'd0);
    e = sb.pop_front();
    chk({tag, " level"},    32'(level),  32'(e.lvl));
    chk({tag, " press"},    32'(press),  32'(e.prs));
    chk({tag, " release"},  32'(rel),    32'(e.rls));
    chk({tag, " repeat"},   32'(rep),    32'(e.rpt));
    chk({tag, " level_r0"}, 32'(level2), 32'(e.lvl));
    chk({tag, " repeat_r0"}, 32'(rep2),  32'(e.rpt0));
    if (rep2[0]) rep0_cnt++;
  endtask

  initial begin
    logic any_out;
    // Reset with keys released.
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({tick, level, press, rel, rep}), 32'd0);
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step("idle", 2'b11);

    // ch0 pressed and held; ch1 bounces every tick for 12 ticks, then released.
    for (int i = 0; i < 23; i++) begin
      if (i < 12) step("hold_bounce", {((i % 2) == 0), 1'b0});
      else        step("hold", 2'b10);
    end

    // Release ch0: RELEASE on the 3rd high sample suppresses a due REPEAT.
    for (int i = 0; i < 5; i++) step("release", 2'b11);
    chk("r0 single repeat", 32'(rep0_cnt), 32'd1);

    // Both channels pressed together.
    for (int i = 0; i < 5; i++) step("both", 2'b00);

    // Reset mid-hold: outputs drop at once, no RELEASE appears.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midhold reset level", 32'({level, level2}), 32'd0);
    any_out = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_out = any_out | (|{tick, level, press, rel, rep, level2, press2, rel2, rep2});
    end
    chk("midhold reset quiet", 32'(any_out), 32'd0);
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) step("after_reset", 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
